fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised operand-bypass and load-use interlock block for the issue→execute boundary of the MIPS pipeline. It tracks every in-flight register write in an internal shift-register scoreboard, one entry per post-issue stage. Each read port is forwarded from the youngest producer whose result exists. When the youngest producer is a load whose data is not yet available, the block asserts a stall and inserts a bubble. It supports any number of read ports, any pipeline depth and a configurable load-ready stage, and it counts interlock cycles for performance monitoring.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; address 0 is hard-wired zero
- NUM_RD, 2, number of read ports
- DEPTH, 3, tracked stages after issue (0 = EX, 1 = MEM, 2 = WB)
- LOAD_READY, 2, lowest stage index at which load data is valid; range 0..DEPTH-1
- CNT_W, 16, interlock counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  instruction at issue presents operand reads this cycle
- rd_addr  in  NUM_RD*REG_AW  read addresses; port p is at [p*REG_AW +: REG_AW]
- rf_data  in  NUM_RD*DATA_W  register-file read data, per port
- wr_en  in  1  issuing instruction writes a register
- wr_rd  in  REG_AW  destination of the issuing instruction
- wr_is_load  in  1  issuing instruction is a load
- stage_data  in  DEPTH*DATA_W  result currently held in stage k, at [k*DATA_W +: DATA_W]
- hold  in  1  global pipeline freeze (cache miss etc.)
- flush  in  1  squash the instruction in stage 0
- op_data  out  NUM_RD*DATA_W  forwarded operands, combinational
- stall  out  1  load-use interlock, combinational
- stall_cnt  out  CNT_W  saturating count of interlock cycles, registered

## Operation
- Each scoreboard entry k (0..DEPTH-1) holds {vld, rd, is_load}.
- An entry is recorded vld=1 only if wr_en=1 and wr_rd≠0.
- Forwarding for port p:
  - Find the lowest k with vld[k] and rd[k]==rd_addr[p] and rd_addr[p]≠0 (youngest match wins).
  - Match found: op_data[p] = stage_data[k].
  - No match, or rd_addr[p]==0: op_data[p] = rf_data[p]. The register file writes before it reads, so producers that have left stage DEPTH-1 are covered.
- Interlock: stall = issue_valid and, for some port, the youngest match has is_load=1 and k < LOAD_READY. When stall=1, op_data is still driven but is don't-care.
- Scoreboard update when hold=0:
  - entry[k] <= entry[k-1] for k≥1.
  - entry[0] <= {1, wr_rd, wr_is_load} if issue_valid & ~stall & ~flush & wr_en & (wr_rd≠0); otherwise entry[0] becomes invalid (bubble).
- Scoreboard update when hold=1: no shift. If flush=1, entry[0].vld <= 0; all other entries are unchanged.
- flush with hold=0: entry[0] receives a bubble. The flushed instruction's old entry[0] still shifts to entry[1]. The controller asserts flush only for the stage-0 instruction before it advances, so flush and shift refer to the instruction entering stage 0.
- stall_cnt increments when stall & ~hold and saturates at 2^CNT_W-1.
- Reset (rst_n=0, asynchronous): all vld <= 0, stall_cnt <= 0. Outputs during and after reset: stall=0, op_data=rf_data, stall_cnt=0.
- Reset asserted mid-operation discards all in-flight entries immediately. The first cycle after release behaves as an empty scoreboard.

## Timing
- op_data and stall are combinational from rd_addr, rf_data, stage_data, issue_valid and the scoreboard, with zero-cycle latency.
- A producer issued in cycle t is visible in entry 0 from cycle t+1, entry k from cycle t+1+k (hold=0).
- With defaults, a load followed immediately by a dependent instruction stalls for 2 cycles. Forwarding comes from stage_data[2] on the third cycle.
- The block never stalls for non-load producers.
- The block never forwards from an entry shadowed by a younger match, including when the younger match is a stalling load.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with issue_valid=1 and rd_addr={5,3} → stall=0, op_data=rf_data, stall_cnt=0. Release; the first issue sees an empty scoreboard.
- ALU chain:
  - Issue wr_rd=8 (non-load), then a read of r8 next cycle with stage_data[0]=0x1234 → op_data port0=0x1234, stall=0.
  - Same read one cycle later instead → op_data=stage_data[1].
- Youngest-match priority: issue writes to r4 in two consecutive cycles, then read r4 → op_data=stage_data[0], not stage_data[1].
- Load-use:
  - Issue a load to r9, then hold issue_valid=1 reading r9 on port1 → stall=1 for exactly 2 cycles and stall_cnt=2.
  - Third cycle: stall=0, op_data port1=stage_data[2].
- Zero register and aging:
  - Write to r0, then read r0 → rf_data, no stall.
  - Write to r7, wait 3 idle cycles, then read r7 → rf_data.
- Hold/flush:
  - Load to r2 in entry 0, hold=1 for 4 cycles while reading r2 → stall stays 1, stall_cnt unchanged.
  - Assert flush with hold=1 → entry 0 cleared, stall drops to 0 the next cycle.
  - Separately, preload stall_cnt near its maximum and keep stalling → stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard_if
//   Bundles the issue-side request, execute-side stage results and the
//   forwarding/interlock responses of fwd_scoreboard.
//
//   master : pipeline controller (drives issue info, stage data, hold/flush)
//   slave  : fwd_scoreboard (returns op_data, stall, stall_cnt)
//
//   issue_valid  instruction at issue presents operand reads this cycle
//   rd_addr      read addresses, port p at [p*REG_AW +: REG_AW]
//   rf_data      register-file read data, port p at [p*DATA_W +: DATA_W]
//   wr_en        issuing instruction writes a register
//   wr_rd        destination of the issuing instruction
//   wr_is_load   issuing instruction is a load
//   stage_data   result held in stage k at [k*DATA_W +: DATA_W]
//   hold         global pipeline freeze
//   flush        squash the instruction entering stage 0
//   op_data      forwarded operands (combinational)
//   stall        load-use interlock (combinational)
//   stall_cnt    saturating interlock cycle count (registered)
// ---------------------------------------------------------------------------
interface fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  logic                     issue_valid;
  logic [NUM_RD*REG_AW-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rf_data;
  logic                     wr_en;
  logic [REG_AW-1:0]        wr_rd;
  logic                     wr_is_load;
  logic [DEPTH*DATA_W-1:0]  stage_data;
  logic                     hold;
  logic                     flush;
  logic [NUM_RD*DATA_W-1:0] op_data;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output issue_valid, rd_addr, rf_data, wr_en, wr_rd, wr_is_load,
           stage_data, hold, flush,
    input  op_data, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, rd_addr, rf_data, wr_en, wr_rd, wr_is_load,
           stage_data, hold, flush,
    output op_data, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//   Operand bypass and load-use interlock for the issue->execute boundary.
//   A shift-register scoreboard holds one {vld, rd, isLoad} entry per
//   post-issue stage (entry 0 = youngest). Each read port takes its operand
//   from the youngest in-flight producer of that register, or from the
//   register file when there is none. A youngest producer that is a load
//   still short of LOAD_READY raises stall and a bubble enters stage 0.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fwd_scoreboard_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_RD     = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              isLoad;
  } entryT;

  entryT                    sb [DEPTH];
  logic [CNT_W-1:0]         stallCnt;
  logic [NUM_RD-1:0]        loadHazard;
  logic [REG_AW-1:0]        portAddr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] opData;
  logic                     stall;
  logic                     recordEn;

  // Per-port bypass select. Entries are scanned oldest to youngest so that a
  // younger match simply overwrites an older one; the hazard flag is taken
  // from the same (youngest) match, so a stalling load also shadows any
  // older forwardable producer.
  // NOTE: every variable here gets a default before any conditional update,
  // otherwise the tool infers a latch to hold the old value.
  always_comb begin
    opData = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      // NOTE: combinational logic uses blocking '=' so later statements see
      // the updated value; clocked state below uses non-blocking '<='.
      portAddr[p]   = bus.rd_addr[p*REG_AW +: REG_AW];
      loadHazard[p] = 1'b0;
      opData[p*DATA_W +: DATA_W] = bus.rf_data[p*DATA_W +: DATA_W];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (sb[k].vld && (sb[k].rd == portAddr[p]) && (portAddr[p] != '0)) begin
          opData[p*DATA_W +: DATA_W] = bus.stage_data[k*DATA_W +: DATA_W];
          loadHazard[p] = sb[k].isLoad && (k < LOAD_READY);
        end
      end
    end
  end

  assign stall    = bus.issue_valid && (|loadHazard);
  assign recordEn = bus.issue_valid && !stall && !bus.flush &&
                    bus.wr_en && (bus.wr_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so every
      // entry is cleared; an in-flight write must never survive reset.
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      stallCnt <= '0;
    end else begin
      if (!bus.hold) begin
        for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
        sb[0] <= recordEn ? entryT'{vld: 1'b1, rd: bus.wr_rd, isLoad: bus.wr_is_load}
                          : entryT'('0);
      end else if (bus.flush) begin
        // Frozen pipeline: only the squashed stage-0 instruction disappears.
        sb[0].vld <= 1'b0;
      end

      if (stall && !bus.hold && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  assign bus.op_data   = opData;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_scoreboard
//   Bench for fwd_scoreboard. Expected values are pushed to expQ as stimulus
//   is driven and popped when the outputs are sampled on the falling edge.
//   dut uses default parameters; dut2 (DEPTH=16, LOAD_READY=15) stalls 15
//   cycles out of 16, which lets stall_cnt reach its 16-bit ceiling quickly.
// ---------------------------------------------------------------------------
module tb_fwd_scoreboard;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;
  localparam logic [31:0] ST0 = 32'h0000_1234;
  localparam logic [31:0] ST1 = 32'h5555_1111;
  localparam logic [31:0] ST2 = 32'h7777_2222;

  logic clk;
  logic rst_n;

  fwd_scoreboard_if bus ();
  fwd_scoreboard_if #(.DEPTH(16)) bus2 ();

  fwd_scoreboard dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fwd_scoreboard #(.DEPTH(16), .LOAD_READY(15)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [31:0] expQ[$];
  logic [31:0] e;
  logic [31:0] op0;
  logic [31:0] op1;
  int          total;
  int          bad;
  int          expCnt;

  assign op0 = bus.op_data[31:0];
  assign op1 = bus.op_data[63:32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wrd, input logic ld);
    bus.issue_valid = iv;
    bus.rd_addr     = {a1, a0};
    bus.wr_en       = we;
    bus.wr_rd       = wrd;
    bus.wr_is_load  = ld;
    bus.hold        = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 5'd5, 1'b1, 5'd3, 1'b1);
    for (int c = 0; c < 3; c++) begin
      expQ.push_back(32'd0); expQ.push_back(RF0); expQ.push_back(RF1); expQ.push_back(32'd0);
      @(negedge clk);
      e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL reset_stall got=%h want=%h", bus.stall, e); end
      e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL reset_op0 got=%h want=%h", op0, e); end
      e = expQ.pop_front(); total++; if (op1 !== e) begin bad++; $display("FAIL reset_op1 got=%h want=%h", op1, e); end
      e = expQ.pop_front(); total++; if (32'(bus.stall_cnt) !== e) begin bad++; $display("FAIL reset_cnt got=%h want=%h", bus.stall_cnt, e); end
      tick();
    end
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0);
    expQ.push_back(RF0); expQ.push_back(RF1); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL post_reset_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (op1 !== e) begin bad++; $display("FAIL post_reset_op1 got=%h want=%h", op1, e); end
    e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL post_reset_stall got=%h want=%h", bus.stall, e); end
    tick();
    drain();
  endtask

  task automatic test_alu_chain();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0); tick();
    drive(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(ST0); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL alu_ex_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL alu_ex_stall got=%h want=%h", bus.stall, e); end
    tick();
    drain();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0); tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(ST1);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL alu_mem_op0 got=%h want=%h", op0, e); end
    tick();
    expQ.push_back(ST2);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL alu_wb_op0 got=%h want=%h", op0, e); end
    tick();
    expQ.push_back(RF0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL alu_retired_op0 got=%h want=%h", op0, e); end
    tick();
    drain();
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0); tick();
    drive(1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0);
    expQ.push_back(ST0); expQ.push_back(ST0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL youngest_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (op1 !== e) begin bad++; $display("FAIL youngest_op1 got=%h want=%h", op1, e); end
    tick();
    expQ.push_back(ST1);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL youngest_aged_op0 got=%h want=%h", op0, e); end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1); tick();
    for (int c = 0; c < 2; c++) begin
      // The stalled instruction also claims r10; it must not be recorded.
      drive(1'b1, 5'd0, 5'd9, 1'b1, 5'd10, 1'b0);
      expQ.push_back(32'd1); expQ.push_back(32'(expCnt));
      @(negedge clk);
      e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL load_use_stall got=%h want=%h", bus.stall, e); end
      e = expQ.pop_front(); total++; if (32'(bus.stall_cnt) !== e) begin bad++; $display("FAIL load_use_cnt got=%h want=%h", bus.stall_cnt, e); end
      expCnt++;
      tick();
    end
    drive(1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0);
    expQ.push_back(32'd0); expQ.push_back(ST2); expQ.push_back(32'd2);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL load_ready_stall got=%h want=%h", bus.stall, e); end
    e = expQ.pop_front(); total++; if (op1 !== e) begin bad++; $display("FAIL load_ready_op1 got=%h want=%h", op1, e); end
    e = expQ.pop_front(); total++; if (32'(bus.stall_cnt) !== e) begin bad++; $display("FAIL load_ready_cnt got=%h want=%h", bus.stall_cnt, e); end
    tick();
    drive(1'b1, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(RF0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL stall_no_record got=%h want=%h", op0, e); end
    tick();
    drain();
  endtask

  task automatic test_shadow();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1); tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
      expQ.push_back(32'd1);
      @(negedge clk);
      e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL shadow_stall got=%h want=%h", bus.stall, e); end
      expCnt++;
      tick();
    end
    expQ.push_back(32'd0); expQ.push_back(ST2);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL shadow_release_stall got=%h want=%h", bus.stall, e); end
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL shadow_release_op0 got=%h want=%h", op0, e); end
    tick();
    drain();
  endtask

  task automatic test_zero_aging();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1); tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(RF0); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL r0_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL r0_stall got=%h want=%h", bus.stall, e); end
    tick();
    drain();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0); tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
    drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(RF0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL aged_r7_op0 got=%h want=%h", op0, e); end
    tick();
    drain();
  endtask

  task automatic test_hold_flush();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 1'b1); tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
      bus.hold = 1'b1;
      expQ.push_back(32'd1); expQ.push_back(32'(expCnt));
      @(negedge clk);
      e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL hold_stall got=%h want=%h", bus.stall, e); end
      e = expQ.pop_front(); total++; if (32'(bus.stall_cnt) !== e) begin bad++; $display("FAIL hold_cnt got=%h want=%h", bus.stall_cnt, e); end
      tick();
    end
    drive(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    tick();
    drive(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(32'd0); expQ.push_back(RF0); expQ.push_back(32'(expCnt));
    @(negedge clk);
    e = expQ.pop_front(); total++; if (32'(bus.stall) !== e) begin bad++; $display("FAIL flush_hold_stall got=%h want=%h", bus.stall, e); end
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL flush_hold_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (32'(bus.stall_cnt) !== e) begin bad++; $display("FAIL flush_hold_cnt got=%h want=%h", bus.stall_cnt, e); end
    tick();
    drain();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd11, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0);
    bus.flush = 1'b1;
    tick();
    drive(1'b1, 5'd11, 5'd12, 1'b0, 5'd0, 1'b0);
    expQ.push_back(ST1); expQ.push_back(RF1);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL flush_shift_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (op1 !== e) begin bad++; $display("FAIL flush_bubble_op1 got=%h want=%h", op1, e); end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0); tick();
    drive(1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0);
    expQ.push_back(ST0);
    #2;
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL pre_reset_op0 got=%h want=%h", op0, e); end
    rst_n = 1'b0;
    expQ.push_back(RF0); expQ.push_back(32'd0);
    #1;
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL async_reset_op0 got=%h want=%h", op0, e); end
    e = expQ.pop_front(); total++; if (32'(bus.stall_cnt) !== e) begin bad++; $display("FAIL async_reset_cnt got=%h want=%h", bus.stall_cnt, e); end
    expCnt = 0;
    tick();
    rst_n = 1'b1;
    expQ.push_back(RF0);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (op0 !== e) begin bad++; $display("FAIL after_mid_reset_op0 got=%h want=%h", op0, e); end
    tick();
    drain();
  endtask

  // Constant "load r9 reading r9" on dut2: cycle 0 issues, then each period
  // of 16 cycles is 15 stalls followed by one issue.
  task automatic test_saturate();
    bus2.issue_valid = 1'b1;
    bus2.rd_addr     = {5'd0, 5'd9};
    bus2.wr_en       = 1'b1;
    bus2.wr_rd       = 5'd9;
    bus2.wr_is_load  = 1'b1;
    repeat (32) tick();
    expQ.push_back(32'd30);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (32'(bus2.stall_cnt) !== e) begin bad++; $display("FAIL sat_partial_cnt got=%h want=%h", bus2.stall_cnt, e); end
    tick();
    repeat (69903 - 33) tick();
    expQ.push_back(32'h0000_FFFE);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (32'(bus2.stall_cnt) !== e) begin bad++; $display("FAIL sat_below_max got=%h want=%h", bus2.stall_cnt, e); end
    tick();
    repeat (70000 - 69904) tick();
    expQ.push_back(32'h0000_FFFF);
    @(negedge clk);
    e = expQ.pop_front(); total++; if (32'(bus2.stall_cnt) !== e) begin bad++; $display("FAIL sat_max_cnt got=%h want=%h", bus2.stall_cnt, e); end
    tick();
    bus2.issue_valid = 1'b0;
    bus2.wr_en       = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    expCnt = 0;
    rst_n  = 1'b0;
    bus.rf_data      = {RF1, RF0};
    bus.stage_data   = {ST2, ST1, ST0};
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    bus2.issue_valid = 1'b0;
    bus2.rd_addr     = '0;
    bus2.rf_data     = {RF1, RF0};
    bus2.wr_en       = 1'b0;
    bus2.wr_rd       = '0;
    bus2.wr_is_load  = 1'b0;
    bus2.stage_data  = '0;
    bus2.hold        = 1'b0;
    bus2.flush       = 1'b0;

    test_reset();
    test_alu_chain();
    test_youngest();
    test_load_use();
    test_shadow();
    test_zero_aging();
    test_hold_flush();
    test_reset_mid();
    test_saturate();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
